// File: rtl/seed_key_sched_ctx.sv
// rtl/seed_key_sched_ctx.sv - SEED key-schedule engine storing expanded round keys in several contexts
// G-function and key-schedule FSM with a registered 1-cycle round-key read port.

module seed_g (
    input  logic [31:0] i_x,
    output logic [31:0] o_z
);
    localparam logic [7:0] S1 [256] = '{
        8'hA9,8'h85,8'hD6,8'hD3,8'h54,8'h1D,8'hAC,8'h25,8'h5D,8'h43,8'h18,8'h1E,8'h51,8'hFC,8'hCA,8'h63,
        8'h28,8'h44,8'h20,8'h9D,8'hE0,8'hE2,8'hC8,8'h17,8'hA5,8'h8F,8'h03,8'h7B,8'hBB,8'h13,8'hD2,8'hEE,
        8'h70,8'h8C,8'h3F,8'hA8,8'h32,8'hDD,8'hF6,8'h74,8'hEC,8'h95,8'h0B,8'h57,8'h5C,8'h5B,8'hBD,8'h01,
        8'h24,8'h1C,8'h73,8'h98,8'h10,8'hCC,8'hF2,8'hD9,8'h2C,8'hE7,8'h72,8'h83,8'h9B,8'hD1,8'h86,8'hC9,
        8'h60,8'h50,8'hA3,8'hEB,8'h0D,8'hB6,8'h9E,8'h4F,8'hB7,8'h5A,8'hC6,8'h78,8'hA6,8'h12,8'hAF,8'hD5,
        8'h61,8'hC3,8'hB4,8'h41,8'h52,8'h7D,8'h8D,8'h08,8'h1F,8'h99,8'h00,8'h19,8'h04,8'h53,8'hF7,8'hE1,
        8'hFD,8'h76,8'h2F,8'h27,8'hB0,8'h8B,8'h0E,8'hAB,8'hA2,8'h6E,8'h93,8'h4D,8'h69,8'h7C,8'h09,8'h0A,
        8'hBF,8'hEF,8'hF3,8'hC5,8'h87,8'h14,8'hFE,8'h64,8'hDE,8'h2E,8'h4B,8'h1A,8'h06,8'h21,8'h6B,8'h66,
        8'h02,8'hF5,8'h92,8'h8A,8'h0C,8'hB3,8'h7E,8'hD0,8'h7A,8'h47,8'h96,8'hE5,8'h26,8'h80,8'hAD,8'hDF,
        8'hA1,8'h30,8'h37,8'hAE,8'h36,8'h15,8'h22,8'h38,8'hF4,8'hA7,8'h45,8'h4C,8'h81,8'hE9,8'h84,8'h97,
        8'h35,8'hCB,8'hCE,8'h3C,8'h71,8'h11,8'hC7,8'h89,8'h75,8'hFB,8'hDA,8'hF8,8'h94,8'h59,8'h82,8'hC4,
        8'hFF,8'h49,8'h39,8'h67,8'hC0,8'hCF,8'hD7,8'hB8,8'h0F,8'h8E,8'h42,8'h23,8'h91,8'h6C,8'hDB,8'hA4,
        8'h34,8'hF1,8'h48,8'hC2,8'h6F,8'h3D,8'h2D,8'h40,8'hBE,8'h3E,8'hBC,8'hC1,8'hAA,8'hBA,8'h4E,8'h55,
        8'h3B,8'hDC,8'h68,8'h7F,8'h9C,8'hD8,8'h4A,8'h56,8'h77,8'hA0,8'hED,8'h46,8'hB5,8'h2B,8'h65,8'hFA,
        8'hE3,8'hB9,8'hB1,8'h9F,8'h5E,8'hF9,8'hE6,8'hB2,8'h31,8'hEA,8'h6D,8'h5F,8'hE4,8'hF0,8'hCD,8'h88,
        8'h16,8'h3A,8'h58,8'hD4,8'h62,8'h29,8'h07,8'h33,8'hE8,8'h1B,8'h05,8'h79,8'h90,8'h6A,8'h2A,8'h9A
    };
    localparam logic [7:0] S2 [256] = '{
        8'h38,8'hE8,8'h2D,8'hA6,8'hCF,8'hDE,8'hB3,8'hB8,8'hAF,8'h60,8'h55,8'hC7,8'h44,8'h6F,8'h6B,8'h5B,
        8'hC3,8'h62,8'h33,8'hB5,8'h29,8'hA0,8'hE2,8'hA7,8'hD3,8'h91,8'h11,8'h06,8'h1C,8'hBC,8'h36,8'h4B,
        8'hEF,8'h88,8'h6C,8'hA8,8'h17,8'hC4,8'h16,8'hF4,8'hC2,8'h45,8'hE1,8'hD6,8'h3F,8'h3D,8'h8E,8'h98,
        8'h28,8'h4E,8'hF6,8'h3E,8'hA5,8'hF9,8'h0D,8'hDF,8'hD8,8'h2B,8'h66,8'h7A,8'h27,8'h2F,8'hF1,8'h72,
        8'h42,8'hD4,8'h41,8'hC0,8'h73,8'h67,8'hAC,8'h8B,8'hF7,8'hAD,8'h80,8'h1F,8'hCA,8'h2C,8'hAA,8'h34,
        8'hD2,8'h0B,8'hEE,8'hE9,8'h5D,8'h94,8'h18,8'hF8,8'h57,8'hAE,8'h08,8'hC5,8'h13,8'hCD,8'h86,8'hB9,
        8'hFF,8'h7D,8'hC1,8'h31,8'hF5,8'h8A,8'h6A,8'hB1,8'hD1,8'h20,8'hD7,8'h02,8'h22,8'h04,8'h68,8'h71,
        8'h07,8'hDB,8'h9D,8'h99,8'h61,8'hBE,8'hE6,8'h59,8'hDD,8'h51,8'h90,8'hDC,8'h9A,8'hA3,8'hAB,8'hD0,
        8'h81,8'h0F,8'h47,8'h1A,8'hE3,8'hEC,8'h8D,8'hBF,8'h96,8'h7B,8'h5C,8'hA2,8'hA1,8'h63,8'h23,8'h4D,
        8'hC8,8'h9E,8'h9C,8'h3A,8'h0C,8'h2E,8'hBA,8'h6E,8'h9F,8'h5A,8'hF2,8'h92,8'hF3,8'h49,8'h78,8'hCC,
        8'h15,8'hFB,8'h70,8'h75,8'h7F,8'h35,8'h10,8'h03,8'h64,8'h6D,8'hC6,8'h74,8'hD5,8'hB4,8'hEA,8'h09,
        8'h76,8'h19,8'hFE,8'h40,8'h12,8'hE0,8'hBD,8'h05,8'hFA,8'h01,8'hF0,8'h2A,8'h5E,8'hA9,8'h56,8'h43,
        8'h85,8'h14,8'h89,8'h9B,8'hB0,8'hE5,8'h48,8'h79,8'h97,8'hFC,8'h1E,8'h82,8'h21,8'h8C,8'h1B,8'h5F,
        8'h77,8'h54,8'hB2,8'h1D,8'h25,8'h4F,8'h00,8'h46,8'hED,8'h58,8'h52,8'hEB,8'h7E,8'hDA,8'hC9,8'hFD,
        8'h30,8'h95,8'h65,8'h3C,8'hB6,8'hE4,8'hBB,8'h7C,8'h0E,8'h50,8'h39,8'h26,8'h32,8'h84,8'h69,8'h93,
        8'h37,8'hE7,8'h24,8'hA4,8'hCB,8'h53,8'h0A,8'h87,8'hD9,8'h4C,8'h83,8'h8F,8'hCE,8'h3B,8'h4A,8'hB7
    };
    localparam logic [7:0] M0 = 8'hFC;
    localparam logic [7:0] M1 = 8'hF3;
    localparam logic [7:0] M2 = 8'hCF;
    localparam logic [7:0] M3 = 8'h3F;

    logic [7:0] w_y0, w_y1, w_y2, w_y3;
    logic [7:0] w_z0, w_z1, w_z2, w_z3;

    assign w_y0 = S1[i_x[7:0]];
    assign w_y1 = S2[i_x[15:8]];
    assign w_y2 = S1[i_x[23:16]];
    assign w_y3 = S2[i_x[31:24]];

    // Each output byte mixes all four S-box bytes through a rotating mask set.
    assign w_z0 = (w_y0 & M0) ^ (w_y1 & M1) ^ (w_y2 & M2) ^ (w_y3 & M3);
    assign w_z1 = (w_y0 & M1) ^ (w_y1 & M2) ^ (w_y2 & M3) ^ (w_y3 & M0);
    assign w_z2 = (w_y0 & M2) ^ (w_y1 & M3) ^ (w_y2 & M0) ^ (w_y3 & M1);
    assign w_z3 = (w_y0 & M3) ^ (w_y1 & M0) ^ (w_y2 & M1) ^ (w_y3 & M2);

    assign o_z = {w_z3, w_z2, w_z1, w_z0};
endmodule

module seed_key_sched_ctx #(
    parameter int ROUNDS  = 16,
    parameter int NUM_CTX = 2,
    parameter int CTX_W   = 1
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_key_valid,
    output logic               o_key_ready,
    input  logic [127:0]       i_key_in,
    input  logic [CTX_W-1:0]   i_key_ctx,
    output logic               o_busy,
    output logic [NUM_CTX-1:0] o_ctx_ready,
    input  logic               i_rk_req,
    input  logic [CTX_W-1:0]   i_rk_ctx,
    input  logic [3:0]         i_rk_round,
    input  logic               i_enc_dec,
    output logic               o_rk_valid,
    output logic [31:0]        o_rk_out0,
    output logic [31:0]        o_rk_out1,
    output logic               o_rk_err
);
    localparam logic [3:0]  LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [31:0] KC_INIT    = 32'h9E3779B9;

    typedef enum logic {S_IDLE, S_EXPAND} state_t;

    state_t           r_state;
    logic [31:0]      r_a, r_b, r_c, r_d, r_kc;
    logic [3:0]       r_round;
    logic [CTX_W-1:0] r_ctx;
    logic [63:0]      r_mem [NUM_CTX][ROUNDS];

    logic [31:0] w_g0_in, w_g1_in, w_k0, w_k1;
    logic        w_key_ctx_ok, w_accept;
    logic        w_rd_ctx_ok, w_rd_round_ok, w_rd_err;
    logic [3:0]  w_rd_phys;

    assign w_g0_in = r_a + r_c - r_kc;
    assign w_g1_in = r_b - r_d + r_kc;

    seed_g u_g0 (.i_x(w_g0_in), .o_z(w_k0));
    seed_g u_g1 (.i_x(w_g1_in), .o_z(w_k1));

    assign w_key_ctx_ok = 32'(i_key_ctx) < 32'(NUM_CTX);
    assign w_accept     = (r_state == S_IDLE) && i_key_valid && w_key_ctx_ok;

    assign w_rd_ctx_ok   = 32'(i_rk_ctx) < 32'(NUM_CTX);
    assign w_rd_round_ok = {1'b0, i_rk_round} < 5'(ROUNDS);
    assign w_rd_err      = !w_rd_ctx_ok || !w_rd_round_ok || !o_ctx_ready[i_rk_ctx];
    // Decrypt order walks the stored schedule backwards.
    assign w_rd_phys     = i_enc_dec ? i_rk_round : (LAST_ROUND - i_rk_round);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            o_key_ready <= 1'b1;
            o_busy      <= 1'b0;
            o_ctx_ready <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_kc        <= KC_INIT;
            r_round     <= '0;
            r_ctx       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        {r_a, r_b, r_c, r_d}   <= i_key_in;
                        r_kc                   <= KC_INIT;
                        r_round                <= '0;
                        r_ctx                  <= i_key_ctx;
                        o_ctx_ready[i_key_ctx] <= 1'b0;
                        o_key_ready            <= 1'b0;
                        o_busy                 <= 1'b1;
                        r_state                <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (!r_round[0]) begin
                        {r_a, r_b} <= {r_b[7:0], r_a, r_b[31:8]};
                    end else begin
                        {r_c, r_d} <= {r_c[23:0], r_d, r_c[31:24]};
                    end
                    r_kc    <= {r_kc[30:0], r_kc[31]};
                    r_round <= r_round + 4'd1;
                    if (r_round == LAST_ROUND) begin
                        o_ctx_ready[r_ctx] <= 1'b1;
                        o_key_ready        <= 1'b1;
                        o_busy             <= 1'b0;
                        r_state            <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Storage carries no reset; ctx_ready gates every read of it.
    always_ff @(posedge i_clk) begin
        if (!i_reset && r_state == S_EXPAND) begin
            r_mem[r_ctx][r_round] <= {w_k0, w_k1};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rk_valid <= 1'b0;
            o_rk_err   <= 1'b0;
            o_rk_out0  <= '0;
            o_rk_out1  <= '0;
        end else begin
            o_rk_valid <= i_rk_req;
            o_rk_err   <= i_rk_req && w_rd_err;
            if (i_rk_req) begin
                if (w_rd_err) begin
                    o_rk_out0 <= '0;
                    o_rk_out1 <= '0;
                end else begin
                    {o_rk_out0, o_rk_out1} <= r_mem[i_rk_ctx][w_rd_phys];
                end
            end
        end
    end
endmodule

// File: tb/tb_seed_key_sched_ctx.sv
// tb/tb_seed_key_sched_ctx.sv - self-checking bench for seed_key_sched_ctx
module tb_seed_key_sched_ctx;
    localparam logic [7:0] S1 [256] = '{
        8'hA9,8'h85,8'hD6,8'hD3,8'h54,8'h1D,8'hAC,8'h25,8'h5D,8'h43,8'h18,8'h1E,8'h51,8'hFC,8'hCA,8'h63,
        8'h28,8'h44,8'h20,8'h9D,8'hE0,8'hE2,8'hC8,8'h17,8'hA5,8'h8F,8'h03,8'h7B,8'hBB,8'h13,8'hD2,8'hEE,
        8'h70,8'h8C,8'h3F,8'hA8,8'h32,8'hDD,8'hF6,8'h74,8'hEC,8'h95,8'h0B,8'h57,8'h5C,8'h5B,8'hBD,8'h01,
        8'h24,8'h1C,8'h73,8'h98,8'h10,8'hCC,8'hF2,8'hD9,8'h2C,8'hE7,8'h72,8'h83,8'h9B,8'hD1,8'h86,8'hC9,
        8'h60,8'h50,8'hA3,8'hEB,8'h0D,8'hB6,8'h9E,8'h4F,8'hB7,8'h5A,8'hC6,8'h78,8'hA6,8'h12,8'hAF,8'hD5,
        8'h61,8'hC3,8'hB4,8'h41,8'h52,8'h7D,8'h8D,8'h08,8'h1F,8'h99,8'h00,8'h19,8'h04,8'h53,8'hF7,8'hE1,
        8'hFD,8'h76,8'h2F,8'h27,8'hB0,8'h8B,8'h0E,8'hAB,8'hA2,8'h6E,8'h93,8'h4D,8'h69,8'h7C,8'h09,8'h0A,
        8'hBF,8'hEF,8'hF3,8'hC5,8'h87,8'h14,8'hFE,8'h64,8'hDE,8'h2E,8'h4B,8'h1A,8'h06,8'h21,8'h6B,8'h66,
        8'h02,8'hF5,8'h92,8'h8A,8'h0C,8'hB3,8'h7E,8'hD0,8'h7A,8'h47,8'h96,8'hE5,8'h26,8'h80,8'hAD,8'hDF,
        8'hA1,8'h30,8'h37,8'hAE,8'h36,8'h15,8'h22,8'h38,8'hF4,8'hA7,8'h45,8'h4C,8'h81,8'hE9,8'h84,8'h97,
        8'h35,8'hCB,8'hCE,8'h3C,8'h71,8'h11,8'hC7,8'h89,8'h75,8'hFB,8'hDA,8'hF8,8'h94,8'h59,8'h82,8'hC4,
        8'hFF,8'h49,8'h39,8'h67,8'hC0,8'hCF,8'hD7,8'hB8,8'h0F,8'h8E,8'h42,8'h23,8'h91,8'h6C,8'hDB,8'hA4,
        8'h34,8'hF1,8'h48,8'hC2,8'h6F,8'h3D,8'h2D,8'h40,8'hBE,8'h3E,8'hBC,8'hC1,8'hAA,8'hBA,8'h4E,8'h55,
        8'h3B,8'hDC,8'h68,8'h7F,8'h9C,8'hD8,8'h4A,8'h56,8'h77,8'hA0,8'hED,8'h46,8'hB5,8'h2B,8'h65,8'hFA,
        8'hE3,8'hB9,8'hB1,8'h9F,8'h5E,8'hF9,8'hE6,8'hB2,8'h31,8'hEA,8'h6D,8'h5F,8'hE4,8'hF0,8'hCD,8'h88,
        8'h16,8'h3A,8'h58,8'hD4,8'h62,8'h29,8'h07,8'h33,8'hE8,8'h1B,8'h05,8'h79,8'h90,8'h6A,8'h2A,8'h9A
    };
    localparam logic [7:0] S2 [256] = '{
        8'h38,8'hE8,8'h2D,8'hA6,8'hCF,8'hDE,8'hB3,8'hB8,8'hAF,8'h60,8'h55,8'hC7,8'h44,8'h6F,8'h6B,8'h5B,
        8'hC3,8'h62,8'h33,8'hB5,8'h29,8'hA0,8'hE2,8'hA7,8'hD3,8'h91,8'h11,8'h06,8'h1C,8'hBC,8'h36,8'h4B,
        8'hEF,8'h88,8'h6C,8'hA8,8'h17,8'hC4,8'h16,8'hF4,8'hC2,8'h45,8'hE1,8'hD6,8'h3F,8'h3D,8'h8E,8'h98,
        8'h28,8'h4E,8'hF6,8'h3E,8'hA5,8'hF9,8'h0D,8'hDF,8'hD8,8'h2B,8'h66,8'h7A,8'h27,8'h2F,8'hF1,8'h72,
        8'h42,8'hD4,8'h41,8'hC0,8'h73,8'h67,8'hAC,8'h8B,8'hF7,8'hAD,8'h80,8'h1F,8'hCA,8'h2C,8'hAA,8'h34,
        8'hD2,8'h0B,8'hEE,8'hE9,8'h5D,8'h94,8'h18,8'hF8,8'h57,8'hAE,8'h08,8'hC5,8'h13,8'hCD,8'h86,8'hB9,
        8'hFF,8'h7D,8'hC1,8'h31,8'hF5,8'h8A,8'h6A,8'hB1,8'hD1,8'h20,8'hD7,8'h02,8'h22,8'h04,8'h68,8'h71,
        8'h07,8'hDB,8'h9D,8'h99,8'h61,8'hBE,8'hE6,8'h59,8'hDD,8'h51,8'h90,8'hDC,8'h9A,8'hA3,8'hAB,8'hD0,
        8'h81,8'h0F,8'h47,8'h1A,8'hE3,8'hEC,8'h8D,8'hBF,8'h96,8'h7B,8'h5C,8'hA2,8'hA1,8'h63,8'h23,8'h4D,
        8'hC8,8'h9E,8'h9C,8'h3A,8'h0C,8'h2E,8'hBA,8'h6E,8'h9F,8'h5A,8'hF2,8'h92,8'hF3,8'h49,8'h78,8'hCC,
        8'h15,8'hFB,8'h70,8'h75,8'h7F,8'h35,8'h10,8'h03,8'h64,8'h6D,8'hC6,8'h74,8'hD5,8'hB4,8'hEA,8'h09,
        8'h76,8'h19,8'hFE,8'h40,8'h12,8'hE0,8'hBD,8'h05,8'hFA,8'h01,8'hF0,8'h2A,8'h5E,8'hA9,8'h56,8'h43,
        8'h85,8'h14,8'h89,8'h9B,8'hB0,8'hE5,8'h48,8'h79,8'h97,8'hFC,8'h1E,8'h82,8'h21,8'h8C,8'h1B,8'h5F,
        8'h77,8'h54,8'hB2,8'h1D,8'h25,8'h4F,8'h00,8'h46,8'hED,8'h58,8'h52,8'hEB,8'h7E,8'hDA,8'hC9,8'hFD,
        8'h30,8'h95,8'h65,8'h3C,8'hB6,8'hE4,8'hBB,8'h7C,8'h0E,8'h50,8'h39,8'h26,8'h32,8'h84,8'h69,8'h93,
        8'h37,8'hE7,8'h24,8'hA4,8'hCB,8'h53,8'h0A,8'h87,8'hD9,8'h4C,8'h83,8'h8F,8'hCE,8'h3B,8'h4A,8'hB7
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         key_valid = 1'b0, key_ready, busy;
    logic [127:0] key_in = '0;
    logic [0:0]   key_ctx = '0, rk_ctx = '0;
    logic [1:0]   ctx_ready;
    logic         rk_req = 1'b0, enc_dec = 1'b1, rk_valid, rk_err;
    logic [3:0]   rk_round = '0;
    logic [31:0]  rk_out0, rk_out1;

    logic         b_key_valid = 1'b0, b_key_ready, b_busy;
    logic [127:0] b_key_in = '0;
    logic [1:0]   b_key_ctx = '0, b_rk_ctx = '0;
    logic [2:0]   b_ctx_ready;
    logic         b_rk_req = 1'b0, b_enc_dec = 1'b1, b_rk_valid, b_rk_err;
    logic [3:0]   b_rk_round = '0;
    logic [31:0]  b_rk_out0, b_rk_out1;

    seed_key_sched_ctx dut (
        .i_clk(clk), .i_reset(reset), .i_key_valid(key_valid), .o_key_ready(key_ready),
        .i_key_in(key_in), .i_key_ctx(key_ctx), .o_busy(busy), .o_ctx_ready(ctx_ready),
        .i_rk_req(rk_req), .i_rk_ctx(rk_ctx), .i_rk_round(rk_round), .i_enc_dec(enc_dec),
        .o_rk_valid(rk_valid), .o_rk_out0(rk_out0), .o_rk_out1(rk_out1), .o_rk_err(rk_err)
    );

    seed_key_sched_ctx #(.ROUNDS(12), .NUM_CTX(3), .CTX_W(2)) dut12 (
        .i_clk(clk), .i_reset(reset), .i_key_valid(b_key_valid), .o_key_ready(b_key_ready),
        .i_key_in(b_key_in), .i_key_ctx(b_key_ctx), .o_busy(b_busy), .o_ctx_ready(b_ctx_ready),
        .i_rk_req(b_rk_req), .i_rk_ctx(b_rk_ctx), .i_rk_round(b_rk_round), .i_enc_dec(b_enc_dec),
        .o_rk_valid(b_rk_valid), .o_rk_out0(b_rk_out0), .o_rk_out1(b_rk_out1), .o_rk_err(b_rk_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] ks_tmp [16];
    logic [63:0] m16 [2][16];
    logic [1:0]  m16_rdy = '0;
    logic [63:0] m12 [3][16];
    logic [2:0]  m12_rdy = '0;
    logic [65:0] last16 = '0;

    function automatic logic [31:0] g_ref(input logic [31:0] x);
        logic [7:0]  y [4];
        logic [7:0]  m [4];
        logic [7:0]  z;
        logic [31:0] res;
        m[0] = 8'hFC; m[1] = 8'hF3; m[2] = 8'hCF; m[3] = 8'h3F;
        y[0] = S1[x[7:0]];   y[1] = S2[x[15:8]];
        y[2] = S1[x[23:16]]; y[3] = S2[x[31:24]];
        res = '0;
        for (int j = 0; j < 4; j++) begin
            z = '0;
            for (int k = 0; k < 4; k++) z = z ^ (y[k] & m[(j + k) % 4]);
            res[8*j +: 8] = z;
        end
        return res;
    endfunction

    task automatic expand_ref(input logic [127:0] key, input int nr);
        logic [31:0] a, b, c, d, kc;
        logic [63:0] t;
        {a, b, c, d} = key;
        for (int i = 0; i < nr; i++) begin
            kc = (i == 0) ? 32'h9E3779B9 : ((32'h9E3779B9 << i) | (32'h9E3779B9 >> (32 - i)));
            ks_tmp[i] = {g_ref(a + c - kc), g_ref(b - d + kc)};
            if (i % 2 == 0) begin
                t = {a, b}; t = (t >> 8) | (t << 56); {a, b} = t;
            end else begin
                t = {c, d}; t = (t << 8) | (t >> 56); {c, d} = t;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue one read on the 16-round instance and check it against the model state before the edge.
    task automatic read16(input int ctx, input int rnd, input logic ed, input string tag);
        logic [65:0] exp;
        int phys;
        phys = ed ? rnd : 15 - rnd;
        exp  = m16_rdy[ctx] ? {2'b10, m16[ctx][phys]} : {2'b11, 64'h0};
        rk_req = 1'b1; rk_ctx = 1'(ctx); rk_round = 4'(rnd); enc_dec = ed;
        tick();
        rk_req = 1'b0;
        n_tests++;
        if ({rk_valid, rk_err, rk_out0, rk_out1} !== exp) begin
            n_fail++;
            $display("FAIL %s ctx=%0d rnd=%0d ed=%0b got v/e/out=%h required %h", tag, ctx, rnd, ed,
                     {rk_valid, rk_err, rk_out0, rk_out1}, exp);
        end
        last16 = {rk_valid, rk_err, rk_out0, rk_out1};
    endtask

    task automatic read12(input int ctx, input int rnd, input logic ed, input string tag);
        logic [65:0] exp;
        int phys;
        logic ok;
        phys = ed ? rnd : 11 - rnd;
        ok   = (ctx < 3) && (rnd < 12) && m12_rdy[ctx % 3];
        exp  = ok ? {2'b10, m12[ctx % 3][phys % 16]} : {2'b11, 64'h0};
        b_rk_req = 1'b1; b_rk_ctx = 2'(ctx); b_rk_round = 4'(rnd); b_enc_dec = ed;
        tick();
        b_rk_req = 1'b0;
        n_tests++;
        if ({b_rk_valid, b_rk_err, b_rk_out0, b_rk_out1} !== exp) begin
            n_fail++;
            $display("FAIL %s ctx=%0d rnd=%0d ed=%0b got v/e/out=%h required %h", tag, ctx, rnd, ed,
                     {b_rk_valid, b_rk_err, b_rk_out0, b_rk_out1}, exp);
        end
    endtask

    task automatic wait_idle16(input int need, input string tag);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 60) begin
            cnt++;
            tick();
        end
        n_tests++;
        if (cnt != need) begin
            n_fail++;
            $display("FAIL %s busy cycles got %0d required %0d", tag, cnt, need);
        end
    endtask

    task automatic load16(input logic [127:0] key, input int ctx);
        key_valid = 1'b1; key_in = key; key_ctx = 1'(ctx);
        tick();
        key_valid = 1'b0;
        m16_rdy[ctx] = 1'b0;
        wait_idle16(16, "load16_busy");
        expand_ref(key, 16);
        for (int i = 0; i < 16; i++) m16[ctx][i] = ks_tmp[i];
        m16_rdy[ctx] = 1'b1;
        n_tests++;
        if (ctx_ready !== m16_rdy || key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load16_done ctx_ready=%b key_ready=%b required %b/1", ctx_ready, key_ready, m16_rdy);
        end
    endtask

    task automatic check_const(input string tag, input logic [31:0] e0, input logic [31:0] e1);
        n_tests++;
        if ({rk_valid, rk_err, rk_out0, rk_out1} !== {2'b10, e0, e1}) begin
            n_fail++;
            $display("FAIL %s got %h/%h err=%b required %h/%h", tag, rk_out0, rk_out1, rk_err, e0, e1);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        m16_rdy = '0;
        m12_rdy = '0;
        last16  = '0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({key_ready, busy, ctx_ready, rk_valid, rk_err, rk_out0, rk_out1} !== {1'b1, 1'b0, 2'b00, 2'b00, 64'h0}) begin
            n_fail++;
            $display("FAIL reset16 kr=%b busy=%b cr=%b v=%b e=%b out=%h/%h required 1/0/00/0/0/0",
                     key_ready, busy, ctx_ready, rk_valid, rk_err, rk_out0, rk_out1);
        end
        n_tests++;
        if ({b_key_ready, b_busy, b_ctx_ready, b_rk_valid, b_rk_err, b_rk_out0, b_rk_out1} !== {1'b1, 1'b0, 3'b000, 2'b00, 64'h0}) begin
            n_fail++;
            $display("FAIL reset12 kr=%b busy=%b cr=%b v=%b e=%b required 1/0/000/0/0",
                     b_key_ready, b_busy, b_ctx_ready, b_rk_valid, b_rk_err);
        end
    endtask

    task automatic test_known_answer();
        load16(128'h0, 0);
        read16(0, 0, 1'b1, "kat_r0_enc");  check_const("kat_r0_enc_const", 32'h7C8F8C7E, 32'hC737A22C);
        read16(0, 1, 1'b1, "kat_r1_enc");  check_const("kat_r1_enc_const", 32'hFF276CDB, 32'hA7CA684A);
        read16(0, 15, 1'b0, "kat_r15_dec"); check_const("kat_r15_dec_const", 32'h7C8F8C7E, 32'hC737A22C);
        read16(0, 14, 1'b0, "kat_r14_dec"); check_const("kat_r14_dec_const", 32'hFF276CDB, 32'hA7CA684A);
        for (int i = 0; i < 16; i++) read16(0, i, 1'(i % 2), "kat_sweep");
    endtask

    task automatic test_ctx_overlap();
        logic [127:0] k1 = 128'h000102030405060708090A0B0C0D0E0F;
        key_valid = 1'b1; key_in = k1; key_ctx = 1'b1;
        for (int cyc = 0; cyc < 17; cyc++) begin
            if (cyc == 16) read16(1, 0, 1'b1, "overlap_final_write_race");
            else           read16(0, $urandom_range(15), 1'($urandom_range(1)), "overlap_ctx0");
            if (cyc == 0) begin key_valid = 1'b0; m16_rdy[1] = 1'b0; end
        end
        n_tests++;
        if (busy !== 1'b0 || ctx_ready !== 2'b11) begin
            n_fail++;
            $display("FAIL overlap_done busy=%b ctx_ready=%b required 0/11", busy, ctx_ready);
        end
        expand_ref(k1, 16);
        for (int i = 0; i < 16; i++) m16[1][i] = ks_tmp[i];
        m16_rdy[1] = 1'b1;
        read16(1, 0, 1'b1, "overlap_ctx1_r0"); check_const("overlap_ctx1_r0_const", 32'hC119F584, 32'h5AE033A0);
    endtask

    task automatic test_reset_mid_expand();
        key_valid = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom}; key_ctx = 1'b0;
        tick();
        key_valid = 1'b0;
        repeat (7) tick();
        apply_reset();
        n_tests++;
        if ({key_ready, busy, ctx_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_mid kr=%b busy=%b cr=%b required 1/0/00", key_ready, busy, ctx_ready);
        end
        load16(128'h0, 0);
        read16(0, 0, 1'b1, "reset_mid_reload"); check_const("reset_mid_reload_const", 32'h7C8F8C7E, 32'hC737A22C);
    endtask

    task automatic test_same_edge_race();
        logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1; key_in = k; key_ctx = 1'b0;
        read16(0, 0, 1'b1, "race_old_key");
        key_valid = 1'b0;
        m16_rdy[0] = 1'b0;
        read16(0, 3, 1'b1, "race_during_expand");
        wait_idle16(15, "race_busy");
        expand_ref(k, 16);
        for (int i = 0; i < 16; i++) m16[0][i] = ks_tmp[i];
        m16_rdy[0] = 1'b1;
        read16(0, 7, 1'b0, "race_new_key");
    endtask

    task automatic test_back_to_back(input int n);
        logic [65:0] exp;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(3) != 0) begin
                read16($urandom_range(1), $urandom_range(15), 1'($urandom_range(1)), "b2b_read");
            end else begin
                exp = {2'b00, last16[63:0]};
                tick();
                n_tests++;
                if ({rk_valid, rk_err, rk_out0, rk_out1} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_idle_hold got %h required %h", {rk_valid, rk_err, rk_out0, rk_out1}, exp);
                end
                last16 = {rk_valid, rk_err, rk_out0, rk_out1};
            end
        end
    endtask

    task automatic test_random_keys();
        for (int j = 0; j < 3; j++) begin
            load16({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1));
            test_back_to_back(12);
        end
    endtask

    task automatic test_rounds12();
        int cnt = 0;
        logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
        read12(1, 0, 1'b1, "r12_unloaded");
        b_key_valid = 1'b1; b_key_in = k; b_key_ctx = 2'd1;
        tick();
        b_key_valid = 1'b0;
        while (b_busy === 1'b1 && cnt < 60) begin cnt++; tick(); end
        n_tests++;
        if (cnt != 12 || b_ctx_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL r12_load busy cycles %0d ctx_ready=%b required 12/010", cnt, b_ctx_ready);
        end
        expand_ref(k, 12);
        for (int i = 0; i < 12; i++) m12[1][i] = ks_tmp[i];
        m12_rdy[1] = 1'b1;
        for (int i = 0; i < 12; i++) read12(1, $urandom_range(11), 1'($urandom_range(1)), "r12_read");
        read12(1, 15, 1'b1, "r12_round_15");
        read12(1, 12, 1'b0, "r12_round_12");
        read12(3, 0, 1'b1, "r12_ctx_3");
        b_key_valid = 1'b1; b_key_ctx = 2'd3;
        tick(); tick();
        b_key_valid = 1'b0;
        n_tests++;
        if (b_key_ready !== 1'b1 || b_busy !== 1'b0 || b_ctx_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL r12_bad_key_ctx kr=%b busy=%b cr=%b required 1/0/010", b_key_ready, b_busy, b_ctx_ready);
        end
    endtask

    initial begin
        test_reset();
        test_known_answer();
        test_ctx_overlap();
        test_back_to_back(24);
        test_reset_mid_expand();
        test_same_edge_race();
        test_random_keys();
        test_rounds12();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
